// File: rtl/iic_slave_mem.sv
// I2C target with an internal byte memory answering the 24xx EEPROM command set.
// Define IIC_SLAVE_WR_BUSY_EN to NACK the device address during an emulated write cycle.
module iic_slave_mem #(
    parameter logic [6:0] DEVICE_ADDR    = 7'b1010_000,
    parameter int         ADDR_BYTE_NUM  = 2,
    parameter int         MEM_AW         = 8,
    parameter int         WR_BUSY_CYCLES = 250_000
) (
    input  logic              iic_clk,
    input  logic              iic_rst,
    input  logic              iic_scl,
    input  logic              iic_sda_in,
    output logic              iic_sda_oe,
    output logic              iic_busy,
    output logic              mem_wr_valid,
    output logic [MEM_AW-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data
);

    localparam int         ADDR_W   = ADDR_BYTE_NUM * 8;
    localparam logic [1:0] LAST_IDX = 2'(ADDR_BYTE_NUM - 1);

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        WADDR,
        WADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } state_t;

    state_t            state;
    logic [2:0]        scl_sync;
    logic [2:0]        sda_sync;
    logic              scl_rise;
    logic              scl_fall;
    logic              bus_start;
    logic              bus_stop;
    logic              sda_s;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        tx;
    logic              rw;
    logic              master_nack;
    logic [1:0]        addr_idx;
    logic [ADDR_W-1:0] addr_acc;
    logic [MEM_AW-1:0] ptr;
    logic [MEM_AW-1:0] ptr_inc;
    logic              bus_active;
    logic              dev_blocked;
    logic [7:0]        mem [2**MEM_AW];
    logic [7:0]        rd_byte;
    logic [7:0]        nxt_byte;

    // Bit [1] is the second synchronizer stage, bit [2] the history used for edge detection.
    always_ff @(posedge iic_clk) begin
        if (iic_rst) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], iic_scl};
            sda_sync <= {sda_sync[1:0], iic_sda_in};
        end
    end

    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    assign bus_start = ~sda_sync[1] & sda_sync[2] & scl_sync[1];
    assign bus_stop  = sda_sync[1] & ~sda_sync[2] & scl_sync[1];

    assign ptr_inc  = ptr + MEM_AW'(1);
    assign rd_byte  = mem[ptr];
    assign nxt_byte = mem[ptr_inc];

    // NOTE: the memory array carries no reset, so it maps onto plain RAM.
    always_ff @(posedge iic_clk) begin
        if (mem_wr_valid) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
    end

`ifdef IIC_SLAVE_WR_BUSY_EN
    localparam int BUSY_W = $clog2(WR_BUSY_CYCLES + 1);

    logic [BUSY_W-1:0] busy_cnt;
    logic              wrote;

    always_ff @(posedge iic_clk) begin
        if (iic_rst) begin
            busy_cnt <= '0;
            wrote    <= 1'b0;
        end else begin
            if (bus_stop && wrote) begin
                busy_cnt <= BUSY_W'(WR_BUSY_CYCLES);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - BUSY_W'(1);
            end
            if (bus_stop) begin
                wrote <= 1'b0;
            end else if (mem_wr_valid) begin
                wrote <= 1'b1;
            end
        end
    end

    assign dev_blocked = (busy_cnt != '0);
    assign iic_busy    = bus_active | dev_blocked;
`else
    assign dev_blocked = 1'b0;
    assign iic_busy    = bus_active;
`endif

    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge iic_clk) begin
        if (iic_rst) begin
            state        <= IDLE;
            iic_sda_oe   <= 1'b0;
            bus_active   <= 1'b0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            ptr          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            tx           <= '0;
            rw           <= 1'b0;
            master_nack  <= 1'b0;
            addr_idx     <= '0;
            addr_acc     <= '0;
        end else begin
            mem_wr_valid <= 1'b0;
            if (bus_start) begin
                state      <= DEV_ADDR;
                bit_cnt    <= '0;
                iic_sda_oe <= 1'b0;
                bus_active <= 1'b1;
            end else if (bus_stop) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                iic_sda_oe <= 1'b0;
                bus_active <= 1'b0;
            end else begin
                unique case (state)
                    DEV_ADDR, WADDR, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == DEV_ADDR) begin
                                if (shreg[7:1] == DEVICE_ADDR && !dev_blocked) begin
                                    iic_sda_oe <= 1'b1;
                                    rw         <= shreg[0];
                                    state      <= DEV_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == WADDR) begin
                                iic_sda_oe <= 1'b1;
                                addr_acc   <= ADDR_W'({addr_acc, shreg});
                                if (addr_idx == LAST_IDX) begin
                                    ptr <= MEM_AW'({addr_acc, shreg});
                                end
                                state <= WADDR_ACK;
                            end else begin
                                iic_sda_oe   <= 1'b1;
                                mem_wr_valid <= 1'b1;
                                mem_wr_addr  <= ptr;
                                mem_wr_data  <= shreg;
                                ptr          <= ptr_inc;
                                state        <= WDATA_ACK;
                            end
                        end
                    end
                    DEV_ACK: begin
                        if (scl_fall) begin
                            bit_cnt  <= '0;
                            addr_idx <= '0;
                            tx       <= rd_byte;
                            if (rw) begin
                                iic_sda_oe <= ~rd_byte[7];
                                state      <= RDATA;
                            end else begin
                                iic_sda_oe <= 1'b0;
                                state      <= WADDR;
                            end
                        end
                    end
                    WADDR_ACK: begin
                        if (scl_fall) begin
                            iic_sda_oe <= 1'b0;
                            if (addr_idx == LAST_IDX) begin
                                state <= WDATA;
                            end else begin
                                addr_idx <= addr_idx + 2'd1;
                                state    <= WADDR;
                            end
                        end
                    end
                    WDATA_ACK: begin
                        if (scl_fall) begin
                            iic_sda_oe <= 1'b0;
                            state      <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                iic_sda_oe <= 1'b0;
                                bit_cnt    <= '0;
                                state      <= RACK;
                            end else begin
                                // tx[7] was driven on the previous fall; tx[6] is the next bit.
                                iic_sda_oe <= ~tx[6];
                                tx         <= {tx[6:0], 1'b0};
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            master_nack <= sda_s;
                        end else if (scl_fall) begin
                            if (!master_nack) begin
                                ptr        <= ptr_inc;
                                tx         <= nxt_byte;
                                iic_sda_oe <= ~nxt_byte[7];
                                state      <= RDATA;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    IDLE, IGNORE: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
